level_drop_sched: RTL
=====================

LEVEL_DROP_SCHED -- requirements
Module: level_drop_sched

Interface
REQ-001 The module SHALL have parameter LINES_PER_LEVEL, default 10, meaning the number of cleared lines per level-up (legal range 4..63).
REQ-002 The module SHALL have parameter MAX_LEVEL, default 15, meaning the saturating level ceiling (legal range 1..15).
REQ-003 The module SHALL have parameter SOFT_DROP_PERIOD, default 2_000_000, meaning the clk cycles between soft-drop ticks (legal range 2..2^24-1).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 The module SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port game_start_i, input, 1 bit: one-cycle pulse that starts a game.
REQ-007 The module SHALL have port game_over_i, input, 1 bit: one-cycle pulse that ends a game.
REQ-008 The module SHALL have port pause_i, input, 1 bit: level signal that pauses while high.
REQ-009 The module SHALL have port sys_event_i, input, 1 bit: gravity tick from the period generator.
REQ-010 The module SHALL have port soft_drop_i, input, 1 bit: level signal that is high while the player holds the down key.
REQ-011 The module SHALL have port lines_valid_i, input, 1 bit: one-cycle qualifier for lines_cleared_i.
REQ-012 The module SHALL have port lines_cleared_i, input, 3 bits: number of lines cleared, 0..4.
REQ-013 The module SHALL have port drop_ack_i, input, 1 bit: game core accepts drop_req_o.
REQ-014 The module SHALL have port drop_req_o, output, 1 bit: request to move the piece down by one row.
REQ-015 The module SHALL have port gen_srst_o, output, 1 bit: synchronous reset to the period generator.
REQ-016 The module SHALL have port level_changed_o, output, 1 bit: one-cycle pulse to the period generator.
REQ-017 The module SHALL have port level_o, output, 4 bits: current level, 0-based.
REQ-018 The module SHALL have port lines_total_o, output, 16 bits: total lines cleared in the current game.

Function
REQ-019 The FSM SHALL have the states IDLE, RUN and PAUSED, and SHALL use registered outputs only.
REQ-020 In IDLE, game_start_i SHALL move the FSM to RUN on the next edge and clear level_o, lines_total_o, the lines-in-level counter and the soft-drop counter.
REQ-021 In RUN, pause_i high SHALL move the FSM to PAUSED; in PAUSED, pause_i low SHALL move it back to RUN.
REQ-022 game_over_i in RUN or PAUSED SHALL move the FSM to IDLE and take priority over pause_i and game_start_i in the same cycle.
REQ-023 gen_srst_o SHALL be 1 in IDLE, including the cycle in which game_start_i is sampled, and 0 in RUN and PAUSED.
REQ-024 A drop tick SHALL be sys_event_i=1, or soft-counter expiry, sampled in RUN only; ticks in IDLE and PAUSED SHALL be discarded.
REQ-025 The soft-drop counter SHALL increment while in RUN with soft_drop_i=1, SHALL issue a tick when it reaches SOFT_DROP_PERIOD-1 and then wrap to 0, and SHALL reset to 0 whenever soft_drop_i=0.
REQ-026 A gravity tick and a soft tick in the same cycle SHALL produce one drop only.
REQ-027 drop_req_o SHALL rise on the cycle after a tick and stay high until it is sampled high together with drop_ack_i.
REQ-028 After a handshake with no tick in that cycle, drop_req_o SHALL be 0 on the next cycle.
REQ-029 A tick arriving while drop_req_o=1 and drop_ack_i=0 SHALL be coalesced, with no queueing.
REQ-030 A tick in the same cycle as the handshake SHALL keep drop_req_o=1 on the next cycle as a new request.
REQ-031 Once raised, drop_req_o SHALL NOT be withdrawn by pause; only reset or a transition to IDLE SHALL clear it.
REQ-032 lines_valid_i SHALL be honoured in RUN and PAUSED, with lines_cleared_i values above 4 treated as 4.
REQ-033 On lines_valid_i, lines_total_o SHALL add the cleared count and saturate at 16'hFFFF.
REQ-034 On lines_valid_i, the lines-in-level counter SHALL add the cleared count; if the sum is at least LINES_PER_LEVEL, the counter SHALL become the sum minus LINES_PER_LEVEL.
REQ-035 On the condition of REQ-034, if level_o is below MAX_LEVEL, level_o SHALL increment and level_changed_o SHALL pulse for exactly 1 cycle, on the cycle after lines_valid_i.
REQ-036 At level_o = MAX_LEVEL, the lines-in-level counter SHALL still wrap, but level_o SHALL NOT change and level_changed_o SHALL stay 0.
REQ-037 At most one level-up SHALL occur per lines_valid_i.

Reset
REQ-038 rst_n_i low SHALL immediately force the state to IDLE; drop_req_o=0, level_changed_o=0, gen_srst_o=1, level_o=0, lines_total_o=0 and all counters to 0.
REQ-039 Reset asserted mid-handshake SHALL drop drop_req_o without requiring drop_ack_i.
REQ-040 Release of rst_n_i SHALL be used synchronised to clk externally.

Verification
REQ-041 Reset, then game_start_i, then sys_event_i at cycles 10 and 20 with drop_ack_i 2 cycles after each request: the bench SHALL see exactly 2 handshakes, and gen_srst_o SHALL fall after the start pulse.
REQ-042 drop_ack_i held 0 while 3 sys_event_i arrive: the bench SHALL see drop_req_o stay high with 1 handshake total after the ack; an ack in the same cycle as a tick SHALL give drop_req_o=1 on the next cycle.
REQ-043 SOFT_DROP_PERIOD=4 with soft_drop_i held for 20 cycles and ack always 1: the bench SHALL see 5 ticks, and a sys_event_i coincident with a soft tick SHALL produce a single request.
REQ-044 Clears of 4, 4, then 3: the bench SHALL see lines_total_o=11, level_o=1, the lines-in-level counter at 1, and a single level_changed_o pulse one cycle after the third lines_valid_i.
REQ-045 MAX_LEVEL=1 with 20 lines cleared: the bench SHALL see level_o=1 and exactly 1 level_changed_o pulse.
REQ-046 pause_i high, then sys_event_i, then pause_i low: the bench SHALL see no request; game_over_i asserted during a pending request SHALL give drop_req_o=0 and gen_srst_o=1 on the next cycle.

Source files
------------

// File: rtl/level_drop_sched.sv
`default_nettype none
// ============================================================================
// Module   : level_drop_sched
// Brief    : Game-state FSM that schedules piece drops (gravity and soft drop)
//            and tracks cleared lines and the current level.
// Revision : 1.0 - initial release
// ============================================================================
module level_drop_sched #(
    parameter int LINES_PER_LEVEL  = 10,
    parameter int MAX_LEVEL        = 15,
    parameter int SOFT_DROP_PERIOD = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic        game_start_i,
    input  logic        game_over_i,
    input  logic        pause_i,
    input  logic        sys_event_i,
    input  logic        soft_drop_i,
    input  logic        lines_valid_i,
    input  logic [2:0]  lines_cleared_i,
    input  logic        drop_ack_i,
    output logic        drop_req_o,
    output logic        gen_srst_o,
    output logic        level_changed_o,
    output logic [3:0]  level_o,
    output logic [15:0] lines_total_o
);

    localparam logic [23:0] c_soft_last = 24'(SOFT_DROP_PERIOD - 1);
    localparam logic [6:0]  c_lpl       = 7'(LINES_PER_LEVEL);
    localparam logic [3:0]  c_max_level = 4'(MAX_LEVEL);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t      r_state;
    logic [23:0] r_soft_cnt;
    logic [6:0]  r_lines_in_level;
    logic        r_drop_req;
    logic        r_gen_srst;
    logic        r_level_changed;
    logic [3:0]  r_level;
    logic [15:0] r_lines_total;

    state_t      w_next_state;
    logic        w_run;
    logic        w_active;
    logic        w_soft_tick;
    logic        w_tick;
    logic        w_lines_en;
    logic [2:0]  w_clr;
    logic [6:0]  w_lil_sum;
    logic [6:0]  w_lil_wrap;
    logic        w_level_up;
    logic [16:0] w_total_sum;

    assign w_run       = (r_state == S_RUN);
    assign w_active    = (r_state != S_IDLE);
    assign w_soft_tick = w_run & soft_drop_i & (r_soft_cnt == c_soft_last);
    // Gravity and soft ticks merge into a single drop request.
    assign w_tick      = w_run & (sys_event_i | w_soft_tick);
    assign w_lines_en  = w_active & ~game_over_i & lines_valid_i;
    assign w_clr       = (lines_cleared_i > 3'd4) ? 3'd4 : lines_cleared_i;
    assign w_lil_sum   = r_lines_in_level + {4'd0, w_clr};
    assign w_lil_wrap  = w_lil_sum - c_lpl;
    assign w_level_up  = (w_lil_sum >= c_lpl);
    assign w_total_sum = {1'b0, r_lines_total} + {14'd0, w_clr};

    always_comb begin
        w_next_state = r_state;
        if (w_active && game_over_i) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (game_start_i) w_next_state = S_RUN;
                S_RUN:    if (pause_i)      w_next_state = S_PAUSED;
                S_PAUSED: if (!pause_i)     w_next_state = S_RUN;
                default:                    w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state          <= S_IDLE;
            r_soft_cnt       <= 24'd0;
            r_lines_in_level <= 7'd0;
            r_drop_req       <= 1'b0;
            r_gen_srst       <= 1'b1;
            r_level_changed  <= 1'b0;
            r_level          <= 4'd0;
            r_lines_total    <= 16'd0;
        end else begin
            r_state         <= w_next_state;
            r_gen_srst      <= (w_next_state == S_IDLE);
            r_level_changed <= 1'b0;

            if (!soft_drop_i) begin
                r_soft_cnt <= 24'd0;
            end else if (w_run) begin
                r_soft_cnt <= w_soft_tick ? 24'd0 : r_soft_cnt + 24'd1;
            end

            // A tick in the handshake cycle re-arms the request.
            if (w_next_state == S_IDLE) begin
                r_drop_req <= 1'b0;
            end else if (w_tick) begin
                r_drop_req <= 1'b1;
            end else if (r_drop_req && drop_ack_i) begin
                r_drop_req <= 1'b0;
            end

            if ((r_state == S_IDLE) && game_start_i) begin
                r_level          <= 4'd0;
                r_lines_total    <= 16'd0;
                r_lines_in_level <= 7'd0;
                r_soft_cnt       <= 24'd0;
            end else if (w_lines_en) begin
                r_lines_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
                if (w_level_up) begin
                    r_lines_in_level <= w_lil_wrap;
                    if (r_level < c_max_level) begin
                        r_level         <= r_level + 4'd1;
                        r_level_changed <= 1'b1;
                    end
                end else begin
                    r_lines_in_level <= w_lil_sum;
                end
            end
        end
    end

    assign drop_req_o      = r_drop_req;
    assign gen_srst_o      = r_gen_srst;
    assign level_changed_o = r_level_changed;
    assign level_o         = r_level;
    assign lines_total_o   = r_lines_total;

endmodule
`default_nettype wire
